key_debounce_events: RTL and testbench
======================================

Name: key_debounce_events

Overview:
- Input-side conditioning for the DE10-Lite push-buttons. It sits between the raw active-low KEY pins and counter/display logic.
- Per key: synchronizes, debounces, and converts the raw level into single-cycle press, release and auto-repeat event pulses.
- Counter logic consumes events only and never samples KEY directly.

Parameters:
- N_KEYS, 2, number of independent key channels.
- DEBOUNCE_CYCLES, 250000, consecutive cycles a new synchronized level must persist before it is accepted (5 ms at 50 MHz); must be >= 1.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 means repeat_pulse is tied to 0.
- REPEAT_DELAY_CYCLES, 25000000, cycles from press_pulse to the first repeat_pulse (500 ms).
- REPEAT_RATE_CYCLES, 5000000, cycles between subsequent repeat_pulses (100 ms).

Ports:
- MAX10_CLK1_50  input   1       system clock, 50 MHz.
- RESET_N        input   1       asynchronous active-low reset.
- KEY            input   N_KEYS  raw buttons, active-low (0 = pressed), asynchronous to the clock.
- key_level      output  N_KEYS  debounced state, active-high (1 = pressed).
- press_pulse    output  N_KEYS  one-cycle pulse on an accepted press.
- release_pulse  output  N_KEYS  one-cycle pulse on an accepted release.
- repeat_pulse   output  N_KEYS  one-cycle auto-repeat pulse while held.
- step_pulse     output  N_KEYS  press_pulse OR repeat_pulse (registered, same cycle).

Behaviour:
- Interface: one clock, MAX10_CLK1_50; reset RESET_N is asynchronous and active-low.
- Reset (RESET_N=0, asynchronous):
  - All outputs are 0.
  - Synchronizer flops are 1 (released).
  - Debounce counters are 0; repeat FSMs are IDLE.
- Channels are fully independent. Simultaneous events on different keys appear in the same cycle.
- Synchronizer: 2-flop per key. sync = NOT second flop (active-high pressed).
- Debounce:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - When sync != key_level, the counter increments.
  - When sync == key_level, the counter clears.
  - On the edge where the counter == DEBOUNCE_CYCLES-1 and sync != key_level: key_level <= sync and the counter clears.
- Latency: KEY held constant → key_level changes on the (2 + DEBOUNCE_CYCLES)th rising edge, counting the first edge that samples the new KEY value as edge 1.
- Glitch rule: any reversion of sync before acceptance clears the counter. Glitches shorter than DEBOUNCE_CYCLES never produce events.
- Events:
  - press_pulse and release_pulse are registered on the same edge that key_level changes.
  - Each is high for exactly one cycle.
  - A press and a release of the same key can never coincide.
- Repeat FSM (per key) states: IDLE, HOLD_DELAY, REPEATING. Timer width is clog2(max(DELAY,RATE)+1).
  - IDLE → HOLD_DELAY on the press edge; timer = 0.
  - HOLD_DELAY: timer increments each cycle. When the timer reaches REPEAT_DELAY_CYCLES-1: repeat_pulse, go to REPEATING, timer = 0.
  - REPEATING: when the timer reaches REPEAT_RATE_CYCLES-1: repeat_pulse, timer = 0.
  - An accepted release in any state → IDLE. No repeat_pulse is issued in the release cycle.
- Repeat timing: first repeat_pulse is exactly REPEAT_DELAY_CYCLES cycles after press_pulse; subsequent pulses are spaced exactly REPEAT_RATE_CYCLES apart.
- Timers saturate never; they wrap only via the explicit clear.
- Reset mid-operation:
  - Asserting reset during a hold drops all outputs immediately.
  - If the key is still held after reset deasserts, it is treated as a new press: press_pulse after 2+DEBOUNCE_CYCLES edges, and the repeat sequence restarts from HOLD_DELAY.
- REPEAT_EN=0: the FSM is absent, repeat_pulse=0, and step_pulse = press_pulse.

Decomposition:
- Shared package button_pkg holds:
  - default cycle constants for 50 MHz (DEBOUNCE/DELAY/RATE);
  - the repeat FSM state encoding (IDLE=2'd0, HOLD_DELAY=2'd1, REPEATING=2'd2);
  - a clog2 helper.
- Sub-module key_debounce_channel implements one key (synchronizer, debounce counter, repeat FSM, pulse registers).
- The top instantiates key_debounce_channel N_KEYS times via generate.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=8; 20 ns clock):
- Reset: RESET_N=0 mid-clock with KEY=2'b11 → all outputs 0 immediately. After deassert with KEY=2'b11 for 50 cycles → no events.
- Clean press: KEY[0]=0 from edge 1 → key_level[0]=1 and press_pulse[0]=1 on edge 6 only, step_pulse[0]=1 on edge 6. KEY[0]=1 later → release_pulse[0] on the 6th edge after.
- Bounce: KEY[0] low 3 cycles / high 2 cycles, repeated 5 times → no pulses, key_level[0]=0. Then held low → press_pulse 6 edges after the final low start.
- Hold and repeat: KEY[0] low 60 cycles → press at edge 6, repeat_pulse[0] at edges 26, 34, 42, 50, 58. Release → release_pulse, no further repeats.
- Simultaneous: KEY 2'b11→2'b00 on one edge → press_pulse=2'b11 in the same cycle, and both channels repeat in lockstep.
- Reset mid-hold: RESET_N=0 during REPEATING while KEY[1]=0 held → outputs 0. Deassert → press_pulse[1] 6 edges later, first repeat 20 cycles after that.

Source files
------------

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared constants, repeat FSM encoding and clog2 helper for key conditioning
package button_pkg;

  // Cycle counts for a 50 MHz clock
  localparam int DEFAULT_DEBOUNCE_CYCLES     = 250000;    // 5 ms
  localparam int DEFAULT_REPEAT_DELAY_CYCLES = 25000000;  // 500 ms
  localparam int DEFAULT_REPEAT_RATE_CYCLES  = 5000000;   // 100 ms

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD_DELAY = 2'd1,
    REPEATING  = 2'd2
  } rpt_state_t;

  // Bits needed to hold values 0..value-1; never less than 1
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// rtl/key_debounce_channel.sv - one key: synchronizer, debounce, repeat FSM and event pulses
module key_debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN           = 1,
  parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step_pulse
);

  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          sync;
  logic [CW-1:0] db_cnt;
  logic          accept;
  logic          press_ev;
  logic          release_ev;

  // Raw pin is active-low and asynchronous; flip to active-high after two flops
  assign sync       = ~sync_q2;
  assign accept     = (sync != key_level) && (db_cnt == DB_LAST);
  assign press_ev   = accept & sync;
  assign release_ev = accept & ~sync;

  // Two-flop synchronizer, reset to the released level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Debounce counter: a differing level must persist unbroken before it is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt        <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= press_ev;
      release_pulse <= release_ev;
      if (sync != key_level) begin
        if (db_cnt == DB_LAST) begin
          key_level <= sync;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_repeat
      localparam int TMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                            REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
      localparam int TW = clog2(TMAX + 1);
      localparam logic [TW-1:0] DL_LAST = TW'(REPEAT_DELAY_CYCLES - 1);
      localparam logic [TW-1:0] RT_LAST = TW'(REPEAT_RATE_CYCLES - 1);

      rpt_state_t    state;
      logic [TW-1:0] timer;
      logic          repeat_fire;

      // A release always wins, so no repeat lands in the release cycle
      assign repeat_fire = !release_ev &&
                           (((state == HOLD_DELAY) && (timer == DL_LAST)) ||
                            ((state == REPEATING)  && (timer == RT_LAST)));

      // Repeat FSM: delay after press, then fixed-rate repeats until release
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state        <= IDLE;
          timer        <= '0;
          repeat_pulse <= 1'b0;
          step_pulse   <= 1'b0;
        end else begin
          repeat_pulse <= repeat_fire;
          step_pulse   <= press_ev | repeat_fire;
          if (release_ev) begin
            state <= IDLE;
            timer <= '0;
          end else if (press_ev) begin
            state <= HOLD_DELAY;
            timer <= '0;
          end else begin
            case (state)
              HOLD_DELAY: begin
                if (timer == DL_LAST) begin
                  state <= REPEATING;
                  timer <= '0;
                end else begin
                  timer <= timer + 1'b1;
                end
              end
              REPEATING: begin
                if (timer == RT_LAST) timer <= '0;
                else                  timer <= timer + 1'b1;
              end
              default: begin
                state <= IDLE;
                timer <= '0;
              end
            endcase
          end
        end
      end
    end else begin : g_no_repeat
      assign repeat_pulse = 1'b0;

      // Without auto-repeat a step is just a press
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_pulse <= 1'b0;
        else        step_pulse <= press_ev;
      end
    end
  endgenerate

endmodule

// File: rtl/key_debounce_events.sv
// rtl/key_debounce_events.sv - per-key debounced level and press/release/repeat/step events
module key_debounce_events
  import button_pkg::*;
#(
  parameter int N_KEYS              = 2,
  parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_EN           = 1,
  parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES
) (
  input  logic              MAX10_CLK1_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic [N_KEYS-1:0] step_pulse
);

  // Independent channel per key
  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_channel #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_EN          (REPEAT_EN),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
    ) u_chan (
      .clk          (MAX10_CLK1_50),
      .rst_n        (RESET_N),
      .key_raw      (KEY[i]),
      .key_level    (key_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .repeat_pulse (repeat_pulse[i]),
      .step_pulse   (step_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_events.sv
// tb/tb_key_debounce_events.sv - randomized and directed bench for key_debounce_events
module tb_key_debounce_events;

  localparam int NK = 2;
  localparam int DB = 4;
  localparam int DL = 20;
  localparam int RT = 8;
  localparam int HMAX = 8192;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key;
  logic [NK-1:0] key_level;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;
  logic [NK-1:0] repeat_pulse;
  logic [NK-1:0] step_pulse;

  always #10 clk = ~clk;

  key_debounce_events #(
    .N_KEYS             (NK),
    .DEBOUNCE_CYCLES    (DB),
    .REPEAT_EN          (1),
    .REPEAT_DELAY_CYCLES(DL),
    .REPEAT_RATE_CYCLES (RT)
  ) dut (
    .MAX10_CLK1_50(clk),
    .RESET_N      (rst_n),
    .KEY          (key),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .step_pulse   (step_pulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pressed-samples history per key since the last reset
  bit            hist [NK][HMAX];
  int            n;
  bit            m_level [NK];
  int            press_edge [NK];
  logic [NK-1:0] e_level, e_press, e_rel, e_rep, e_step;
  int            rep0_cnt;
  int            press0_edge;
  bit            seen_both;

  // Sample seen by edge idx (before the first edge everything reads released)
  function automatic bit h(input int k, input int idx);
    if (idx < 1) return 1'b0;
    return hist[k][idx];
  endfunction

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < NK; k++) begin
      m_level[k]    = 1'b0;
      press_edge[k] = 0;
    end
  endtask

  // Level flips once DB consecutive synchronized samples disagree with it;
  // repeats fall at DL + j*RT edges after the press while still held
  task automatic model_edge();
    bit acc;
    bit rel;
    int e;
    n++;
    e_press = '0;
    e_rel   = '0;
    e_rep   = '0;
    for (int k = 0; k < NK; k++) begin
      hist[k][n] = ~key[k];
      acc = 1'b1;
      for (int j = 0; j < DB; j++)
        if (h(k, n - 2 - j) == m_level[k]) acc = 1'b0;
      rel = acc && m_level[k];
      if (m_level[k] && !rel) begin
        e = n - press_edge[k];
        if (e >= DL && ((e - DL) % RT) == 0) e_rep[k] = 1'b1;
      end
      if (acc) begin
        if (!m_level[k]) begin
          e_press[k]    = 1'b1;
          press_edge[k] = n;
        end else begin
          e_rel[k] = 1'b1;
        end
        m_level[k] = ~m_level[k];
      end
      e_level[k] = m_level[k];
    end
    e_step = e_press | e_rep;
  endtask

  // One clock: drive at the falling edge, compare 1 ns after the rising edge
  task automatic cyc(input logic [NK-1:0] kv);
    key = kv;
    @(posedge clk);
    model_edge();
    #1;
    check("key_level", 32'(key_level), 32'(e_level));
    check("press_pulse", 32'(press_pulse), 32'(e_press));
    check("release_pulse", 32'(release_pulse), 32'(e_rel));
    check("repeat_pulse", 32'(repeat_pulse), 32'(e_rep));
    check("step_pulse", 32'(step_pulse), 32'(e_step));
    if (repeat_pulse[0]) rep0_cnt++;
    if (press_pulse[0]) press0_edge = n;
    if (press_pulse == 2'b11) seen_both = 1'b1;
    @(negedge clk);
  endtask

  task automatic cycles(input logic [NK-1:0] kv, input int cnt);
    for (int i = 0; i < cnt; i++) cyc(kv);
  endtask

  // Reset asserted mid-clock; outputs must drop without waiting for an edge
  task automatic reset_pulse(input logic [NK-1:0] kv, input int cnt);
    key   = kv;
    rst_n = 1'b0;
    #1;
    check("rst_key_level", 32'(key_level), 32'h0);
    check("rst_press", 32'(press_pulse), 32'h0);
    check("rst_release", 32'(release_pulse), 32'h0);
    check("rst_repeat", 32'(repeat_pulse), 32'h0);
    check("rst_step", 32'(step_pulse), 32'h0);
    for (int i = 0; i < cnt; i++) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [NK-1:0] kv;
    int            len;
    rst_n       = 1'b0;
    key         = 2'b11;
    rep0_cnt    = 0;
    press0_edge = 0;
    seen_both   = 1'b0;
    model_reset();
    @(negedge clk);
    reset_pulse(2'b11, 2);

    // Idle after reset
    cycles(2'b11, 50);

    // Clean press and release
    cycles(2'b10, 12);
    cycles(2'b11, 12);

    // Bounce shorter than the debounce window, then settle low
    for (int r = 0; r < 5; r++) begin
      cycles(2'b10, 3);
      cycles(2'b11, 2);
    end
    cycles(2'b10, 10);
    cycles(2'b11, 12);

    // Hold and repeat, numbered from a fresh reset
    reset_pulse(2'b11, 2);
    rep0_cnt    = 0;
    press0_edge = 0;
    cycles(2'b10, 60);
    check("hold_press_edge", 32'(press0_edge), 32'd6);
    check("hold_repeat_count", 32'(rep0_cnt), 32'd5);
    cycles(2'b11, 30);

    // Simultaneous press on both keys
    cycles(2'b00, 45);
    check("simultaneous_press", 32'(seen_both), 32'd1);
    cycles(2'b11, 12);

    // Reset in the middle of a repeating hold on key 1
    cycles(2'b01, 40);
    reset_pulse(2'b01, 3);
    cycles(2'b01, 40);
    cycles(2'b11, 12);

    // Randomized segments, occasionally long enough to repeat
    for (int s = 0; s < 80; s++) begin
      kv  = NK'($urandom_range(0, 3));
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 60))
                                        : int'($urandom_range(1, 8));
      cycles(kv, len);
      if (s == 40) reset_pulse(NK'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
    end
    cycles(2'b11, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
